// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters, registered coordinate outputs and a
// delay chain that aligns sync and data-enable with upstream colour latency.
// The optional colour-bar test pattern is enabled by defining VGA_TESTPAT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   PIPE     = 4,
    parameter int   XW       = 10,
    parameter int   YW       = 10,
    parameter int   CW       = 24,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic          clk65,
    input  logic          rst,
    input  logic [CW-1:0] color_in,
    input  logic          test_mode,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] rgb_out,
    output logic          active,
    output logic [XW-1:0] active_x,
    output logic [YW-1:0] active_y,
    output logic          screenend,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Each chain entry carries {x (pattern build only), hsync, vsync, active}
`ifdef VGA_TESTPAT_EN
    localparam int PW = 3 + XW;
`else
    localparam int PW = 3;
`endif

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_active;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_end;
    logic [7:0]    r_frame;
    logic          r_hs;
    logic          r_vs;
    logic [CW-1:0] r_rgb;
    logic [PW-1:0] r_pipe    [0:PIPE];
    logic [PW-1:0] w_pipe_in [0:PIPE];

    logic          w_act_raw;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic          w_end;
    logic          w_de_next;
    logic [CW-1:0] w_color_sel;

    // Raw timing decode from the current counter position
    always_comb begin
        w_act_raw = (r_h < H_ACT) && (r_v < V_ACT);
        w_hs_raw  = (r_h >= H_SS) && (r_h < H_SE);
        w_vs_raw  = (r_v >= V_SS) && (r_v < V_SE);
        w_end     = (r_h == H_LAST) && (r_v == V_LAST);
    end

    // Horizontal and vertical position counters with wrap
    always_ff @(posedge clk65) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            if (r_v == V_LAST) begin
                r_v <= '0;
            end else begin
                r_v <= r_v + 1'b1;
            end
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Register coordinate, visibility, frame-end and raw syncs for this position
    always_ff @(posedge clk65) begin
        if (rst) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_end    <= 1'b0;
            r_frame  <= 8'd0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
        end else begin
            r_active <= w_act_raw;
            r_x      <= w_act_raw ? XW'(r_h) : '0;
            r_y      <= w_act_raw ? YW'(r_v) : '0;
            r_end    <= w_end;
            r_frame  <= r_frame + {7'd0, w_end};
            r_hs     <= w_hs_raw;
            r_vs     <= w_vs_raw;
        end
    end

    // Delay-chain inputs: stage 0 takes the registered timing, others the previous stage
    always_comb begin
        for (int i = 0; i <= PIPE; i++) begin
            w_pipe_in[i] = '0;
        end
`ifdef VGA_TESTPAT_EN
        w_pipe_in[0] = {r_x, r_hs, r_vs, r_active};
`else
        w_pipe_in[0] = {r_hs, r_vs, r_active};
`endif
        for (int i = 1; i <= PIPE; i++) begin
            w_pipe_in[i] = r_pipe[i-1];
        end
    end

    // Delay chain; reset fills every stage with deasserted flags
    always_ff @(posedge clk65) begin
        if (rst) begin
            for (int i = 0; i <= PIPE; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= PIPE; i++) begin
                r_pipe[i] <= w_pipe_in[i];
            end
        end
    end

    // de for the edge about to be taken, so colour lands in the same cycle as de
    assign w_de_next = w_pipe_in[PIPE][0];

`ifdef VGA_TESTPAT_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    endfunction

    logic [XW-1:0] w_x_next;
    logic [XW-1:0] w_bar_q;
    logic [2:0]    w_bar;

    // Bar index from the delayed x, clamped to the last bar
    always_comb begin
        w_x_next = w_pipe_in[PIPE][PW-1:3];
        w_bar_q  = w_x_next / XW'(BAR_W);
        if (w_bar_q > XW'(3'd7)) begin
            w_bar = 3'd7;
        end else begin
            w_bar = w_bar_q[2:0];
        end
    end

    // Colour source: test bars or upstream colour
    always_comb begin
        if (test_mode) begin
            w_color_sel = CW'(bar_color(w_bar));
        end else begin
            w_color_sel = color_in;
        end
    end
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;

    // Colour source: upstream colour only
    always_comb begin
        w_color_sel = color_in;
    end
`endif

    // Colour output register, blanked outside the delayed data-enable
    always_ff @(posedge clk65) begin
        if (rst) begin
            r_rgb <= '0;
        end else if (w_de_next) begin
            r_rgb <= w_color_sel;
        end else begin
            r_rgb <= '0;
        end
    end

    assign active    = r_active;
    assign active_x  = r_x;
    assign active_y  = r_y;
    assign screenend = r_end;
    assign frame_cnt = r_frame;
    assign de        = r_pipe[PIPE][0];
    assign hsync     = r_pipe[PIPE][2] ? HS_POL : ~HS_POL;
    assign vsync     = r_pipe[PIPE][1] ? VS_POL : ~VS_POL;
    assign rgb_out   = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small-timing main, tiny frame for
// frame counter wrap with PIPE=0, default timing for the colour-bar pattern),
// each compared every cycle against a position-arithmetic model.
module tb_vga_timing_gen;

    logic clk65 = 1'b0;
    always #5 clk65 = ~clk65;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- main instance: 20,1,2,3 / 30,1,2,3, PIPE=4 ----------
    logic        rst, test_mode;
    logic [23:0] color_in, rgb_out;
    logic        hsync, vsync, de, active, screenend;
    logic [9:0]  active_x, active_y;
    logic [7:0]  frame_cnt;

    vga_timing_gen #(.H_ACTIVE(20), .H_FP(1), .H_SYNC(2), .H_BP(3),
                     .V_ACTIVE(30), .V_FP(1), .V_SYNC(2), .V_BP(3), .PIPE(4)) u_main (
        .clk65(clk65), .rst(rst), .color_in(color_in), .test_mode(test_mode),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb_out(rgb_out), .active(active),
        .active_x(active_x), .active_y(active_y), .screenend(screenend), .frame_cnt(frame_cnt));

    // ---------------- tiny instance: 1,1,1,1 / 1,1,1,1, PIPE=0 -------------
    logic        rst_s;
    logic [23:0] color_s, rgb_s;
    logic        hsync_s, vsync_s, de_s, active_s, se_s;
    logic [9:0]  x_s, y_s;
    logic [7:0]  frame_s;

    vga_timing_gen #(.H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
                     .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE(0)) u_small (
        .clk65(clk65), .rst(rst_s), .color_in(color_s), .test_mode(1'b0),
        .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .rgb_out(rgb_s), .active(active_s),
        .active_x(x_s), .active_y(y_s), .screenend(se_s), .frame_cnt(frame_s));

    // ---------------- default instance with test_mode=1 -------------------
    logic        rst_t;
    logic [23:0] color_t, rgb_t;
    logic        hsync_t, vsync_t, de_t, active_t, se_t;
    logic [9:0]  x_t, y_t;
    logic [7:0]  frame_t;

    vga_timing_gen u_tp (
        .clk65(clk65), .rst(rst_t), .color_in(color_t), .test_mode(1'b1),
        .hsync(hsync_t), .vsync(vsync_t), .de(de_t), .rgb_out(rgb_t), .active(active_t),
        .active_x(x_t), .active_y(y_t), .screenend(se_t), .frame_cnt(frame_t));

    // ---------------- model ------------------------------------------------
    // n_* = index of the position registered at the last edge (-1 after a reset edge)
    int          n_m = -2, n_s = -2, n_t = -2;
    logic [23:0] col_m;

    function automatic bit m_act(input int p);
        return ((p % 26) < 20) && (((p / 26) % 36) < 30);
    endfunction
    function automatic bit m_hs(input int p);
        return ((p % 26) >= 21) && ((p % 26) < 23);
    endfunction
    function automatic bit m_vs(input int p);
        return (((p / 26) % 36) >= 31) && (((p / 26) % 36) < 33);
    endfunction
    function automatic bit s_act(input int p);
        return ((p % 4) == 0) && (((p / 4) % 4) == 0);
    endfunction

    always @(posedge clk65) begin
        n_m   <= rst   ? -1 : ((n_m == -2) ? -2 : n_m + 1);
        n_s   <= rst_s ? -1 : ((n_s == -2) ? -2 : n_s + 1);
        n_t   <= rst_t ? -1 : ((n_t == -2) ? -2 : n_t + 1);
        col_m <= color_in;
    end

    int h, v, d;
    bit ea, ed;
    logic [23:0] bar_exp;

    always @(negedge clk65) begin
        // main instance
        if (n_m == -1) begin
            chk("rst_active", active, 1'b0);
            chk("rst_x", active_x, 10'd0);
            chk("rst_y", active_y, 10'd0);
            chk("rst_screenend", screenend, 1'b0);
            chk("rst_frame", frame_cnt, 8'd0);
            chk("rst_de", de, 1'b0);
            chk("rst_rgb", rgb_out, 24'd0);
            chk("rst_hsync", hsync, 1'b1);
            chk("rst_vsync", vsync, 1'b1);
        end else if (n_m >= 0) begin
            h  = n_m % 26;
            v  = (n_m / 26) % 36;
            ea = m_act(n_m);
            d  = n_m - 5;
            ed = (d >= 0) && m_act(d);
            chk("active", active, ea);
            chk("active_x", active_x, ea ? h : 0);
            chk("active_y", active_y, ea ? v : 0);
            chk("screenend", screenend, (n_m % 936) == 935);
            chk("frame_cnt", frame_cnt, ((n_m + 1) / 936) % 256);
            chk("de", de, ed);
            chk("rgb", rgb_out, ed ? col_m : 24'd0);
            chk("hsync", hsync, ((d >= 0) && m_hs(d)) ? 1'b0 : 1'b1);
            chk("vsync", vsync, ((d >= 0) && m_vs(d)) ? 1'b0 : 1'b1);
            // hand-computed pins
            case (n_m)
                0:    chk("pin_first_pixel", {active, active_x, active_y}, {1'b1, 10'd0, 10'd0});
                19:   chk("pin_x19", {active, active_x}, {1'b1, 10'd19});
                20:   chk("pin_blank_start", active, 1'b0);
                25:   chk("pin_blank_end_hs", {active, hsync}, {1'b0, 1'b1});
                26:   chk("pin_line1_hs", {active, active_x, active_y, hsync}, {1'b1, 10'd0, 10'd1, 1'b0});
                27:   chk("pin_hs_second", hsync, 1'b0);
                28:   chk("pin_hs_end", hsync, 1'b1);
                934:  chk("pin_se_before", screenend, 1'b0);
                935:  chk("pin_se_first", {screenend, frame_cnt}, {1'b1, 8'd1});
                936:  chk("pin_se_after", {screenend, active, active_x, active_y}, {1'b0, 1'b1, 10'd0, 10'd0});
                1871: chk("pin_se_second", {screenend, frame_cnt}, {1'b1, 8'd2});
                default: ;
            endcase
        end

        // tiny instance: frame of 16 cycles, PIPE=0
        if (n_s >= 0) begin
            ed = (n_s >= 1) && s_act(n_s - 1);
            chk("s_active", active_s, s_act(n_s));
            chk("s_screenend", se_s, (n_s % 16) == 15);
            chk("s_frame", frame_s, ((n_s + 1) / 16) % 256);
            chk("s_de", de_s, ed);
            chk("s_rgb", rgb_s, ed ? 24'h5A5A5A : 24'd0);
            chk("s_hsync", hsync_s, ((n_s >= 1) && (((n_s - 1) % 4) == 2)) ? 1'b0 : 1'b1);
            chk("s_vsync", vsync_s, ((n_s >= 1) && ((((n_s - 1) / 4) % 4) == 2)) ? 1'b0 : 1'b1);
            if (n_s == 15)   chk("pin_s_frame1", frame_s, 8'd1);
            if (n_s == 4094) chk("pin_s_frame255", frame_s, 8'd255);
            if (n_s == 4095) chk("pin_s_frame_wrap", {se_s, frame_s}, {1'b1, 8'd0});
        end

        // default instance: colour at delayed x = 0, 80, 639 of line 0
        if (n_t == 4) chk("tp_before_de", {de_t, rgb_t}, {1'b0, 24'd0});
        if (n_t == 5 || n_t == 85 || n_t == 644) begin
`ifdef VGA_TESTPAT_EN
            bar_exp = (n_t == 5) ? 24'hFFFFFF : ((n_t == 85) ? 24'hFFFF00 : 24'h000000);
`else
            bar_exp = 24'h123456;
`endif
            chk("tp_de", de_t, 1'b1);
            chk("tp_rgb", rgb_t, bar_exp);
        end
        if (n_t == 645) chk("tp_after_line", {de_t, rgb_t}, {1'b0, 24'd0});
    end

    // ---------------- stimulus ---------------------------------------------
    initial begin
        rst = 1'b1; rst_s = 1'b1; rst_t = 1'b1;
        test_mode = 1'b0;
        color_in  = 24'hABCDEF;
        color_s   = 24'h5A5A5A;
        color_t   = 24'h123456;
        repeat (3) @(negedge clk65);
        rst = 1'b0; rst_s = 1'b0; rst_t = 1'b0;
        repeat (1000) @(negedge clk65);
        color_in = 24'h13579B;
        repeat (1950) @(negedge clk65);
        // mid-frame reset: the edge that would register (h=10, v=5) is a reset edge
        for (int i = 0; i < 1000 && (n_m % 936) != 139; i++) @(negedge clk65);
        chk("mid_reset_reach", n_m % 936, 139);
        rst = 1'b1;
        @(negedge clk65);
        rst = 1'b0;
        color_in = 24'h2468AC;
        repeat (1200) @(negedge clk65);
        for (int i = 0; i < 2000 && n_s < 4100; i++) @(negedge clk65);
        chk("small_reach", n_s >= 4100, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
